instr_enc: RTL and testbench

INSTR_ENC -- requirements
Module: instr_enc

---
 rtl/instr_enc.sv | 129 ++++++++++++
 tb/tb_instr_enc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_enc.sv
// rtl/instr_enc.sv - RV32 instruction field encoder with range checks and a 2-entry output FIFO
module instr_enc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [4:0]       rd_addr,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Each FIFO entry is {err, instr}.
  logic [32:0]      mem_q [2];
  logic [32:0]      mem_d [2];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]        enc_word;
  logic               enc_err;
  logic signed [31:0] simm;
  logic               push;
  logic               pop;

  assign simm = imm;

  always_comb begin
    enc_word = 32'h0000_0000;
    enc_err  = 1'b0;
    case (fmt)
      FMT_R: enc_word = {func7, rs2_addr, rs1_addr, func3, rd_addr, opcode};
      FMT_I: begin
        enc_word = {imm[11:0], rs1_addr, func3, rd_addr, opcode};
        enc_err  = (simm < -2048) || (simm > 2047);
      end
      FMT_S: begin
        enc_word = {imm[11:5], rs2_addr, rs1_addr, func3, imm[4:0], opcode};
        enc_err  = (simm < -2048) || (simm > 2047);
      end
      FMT_B: begin
        enc_word = {imm[12], imm[10:5], rs2_addr, rs1_addr, func3, imm[4:1], imm[11], opcode};
        enc_err  = (simm < -4096) || (simm > 4094) || imm[0];
      end
      FMT_U: begin
        enc_word = {imm[31:12], rd_addr, opcode};
        enc_err  = (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd_addr, opcode};
        enc_err  = (simm < -1048576) || (simm > 1048574) || imm[0];
      end
      default: begin
        enc_word = 32'h0000_0000;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Gating on out_valid keeps the outputs zero whenever the FIFO is empty.
  assign out_instr = out_valid ? mem_q[head_q][31:0] : 32'h0000_0000;
  assign out_err   = out_valid ? mem_q[head_q][32]   : 1'b0;
  assign instr_cnt = cnt_q;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[tail_q] = {enc_err, enc_word};
      tail_d        = ~tail_q;
    end
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      cnt_q    <= '0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
// tb/tb_instr_enc.sv - self-checking bench for instr_enc with a queue-based reference model
module tb_instr_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  func3 = 3'd0;
  logic [6:0]  func7 = 7'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] instr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  instr_enc #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .func3(func3), .func7(func7),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from shifted field values and integer range tests.
  function automatic logic [32:0] model_enc(input logic [2:0] f, input logic [31:0] op,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] u);
    longint s;
    logic [31:0] w;
    bit e;
    s = longint'($signed(u));
    e = 1'b0;
    case (f)
      3'd0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: begin
        w = ((u & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((u & 32'h1f) << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | op;
        e = (s < -4096) || (s > 4094) || (u % 2 != 0);
      end
      3'd4: begin
        w = (u & 32'hffff_f000) | (rd << 7) | op;
        e = (u % 4096) != 0;
      end
      3'd5: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 32'hff) << 12) | (rd << 7) | op;
        e = (s < -1048576) || (s > 1048574) || (u % 2 != 0);
      end
      default: begin
        w = 32'd0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  logic [32:0] mq[$];
  int          mcnt = 0;
  bit          m_push, m_pop;
  logic [32:0] m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && (mq.size() < 2);
      m_new  = model_enc(fmt, 32'(opcode), 32'(func3), 32'(func7), 32'(rd_addr),
                         32'(rs1_addr), 32'(rs2_addr), imm);
      if (m_pop) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % 65536;
      end
      if (m_push) mq.push_back(m_new);
    end
  end

  always @(negedge clk) begin
    check("cmp_out_valid", 64'(out_valid), 64'(mq.size() > 0));
    check("cmp_in_ready", 64'(in_ready), 64'(mq.size() < 2));
    check("cmp_instr_cnt", 64'(instr_cnt), 64'(mcnt));
    if (mq.size() > 0) begin
      check("cmp_out_instr", 64'(out_instr), 64'(mq[0][31:0]));
      check("cmp_out_err", 64'(out_err), 64'(mq[0][32]));
    end
  end

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] iv);
    fmt = f; opcode = op; func3 = f3; func7 = f7;
    rd_addr = rd; rs1_addr = rs1; rs2_addr = rs2; imm = iv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word with out_ready high and checks it is at the head one cycle after acceptance.
  task automatic send_chk(input string name, input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] iv, input logic [31:0] exp_w, input logic exp_e);
    int waits;
    out_ready = 1'b1;
    set_fields(f, op, f3, f7, rd, rs1, rs2, iv);
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 10) begin
      step();
      waits++;
    end
    if (!in_ready) check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_instr"}, 64'(out_instr), 64'(exp_w));
    check({name, "_err"}, 64'(out_err), 64'(exp_e));
  endtask

  initial begin
    #3;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_instr_cnt", 64'(instr_cnt), 64'd0);
    check("reset_out_instr", 64'(out_instr), 64'd0);
    step();
    rst_n = 1'b1;

    send_chk("i_addi", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    send_chk("r_add", 3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0);
    send_chk("s_sw", 3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
    send_chk("b_neg4", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
    send_chk("j_800", 3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 32'h0010_00EF, 1'b0);
    send_chk("i_2048", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, 1'b1);
    send_chk("i_neg2048", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2048, 32'h8000_0093, 1'b0);
    send_chk("i_2047", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2047, 32'h7FF0_0093, 1'b0);
    send_chk("b_odd", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h0000_0163, 1'b1);
    send_chk("b_4094", 3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4094, 32'h7E00_0FE3, 1'b0);
    send_chk("fmt7", 3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'h0000_0000, 1'b1);
    send_chk("u_lui", 3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send_chk("u_low", 3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);

    // Model-only boundary and mixed-flow vectors with irregular out_ready.
    begin
      logic [2:0]  vf [12] = '{3'd3, 3'd3, 3'd5, 3'd5, 3'd5, 3'd2, 3'd2, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5};
      logic [31:0] vi [12] = '{32'd4096, -32'sd4096, -32'sd1048576, 32'd1048576, 32'd1048574,
                               -32'sd2049, 32'd2047, 32'd0, 32'hFFFF_FFFF, -32'sd1, 32'hFFFF_F000, 32'd7};
      for (int i = 0; i < 12; i++) begin
        set_fields(vf[i], 7'(i * 9 + 3), 3'(i), 7'(i * 5), 5'(i + 2), 5'(31 - i), 5'(i * 3), vi[i]);
        in_valid  = (i % 4) != 3;
        out_ready = (i % 3) != 1;
        step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      step();
    end

    // Backpressure: three offered, two accepted, then drain in order.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step();
    out_ready = 1'b0;
    set_fields(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    in_valid = 1'b1;
    step();
    imm = 32'd2;
    step();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    imm = 32'd3;
    step();
    in_valid = 1'b0;
    check("bp_head_first", 64'(out_instr), 64'h0010_0093);
    out_ready = 1'b1;
    step();
    check("bp_head_second", 64'(out_instr), 64'h0020_0093);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);
    check("bp_instr_cnt", 64'(instr_cnt), 64'd2);

    // Reset with two words buffered.
    out_ready = 1'b0;
    set_fields(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    check("pre_rst_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_instr_cnt", 64'(instr_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_no_stale", 64'(out_valid), 64'd0);
    send_chk("post_rst_first", 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
